// File: rtl/semaforo_multi.sv
// Purpose : multi-direction traffic-light controller; one direction at a time
//           owns green/yellow, every other direction shows red.
// Latency : Moore machine; inputs act on the next rising edge and all outputs
//           decode from registers only.
// Backpressure: none; the sensor and emerg levels are sampled every cycle.
//
// Ports:
//   clock      - the single clock
//   reset      - synchronous, active-high; forces GREEN on direction 0
//   sensor     - bit d high = traffic waiting on direction d
//   emerg      - emergency preemption request (level)
//   light      - light[2d+1:2d] for direction d: GREEN=00, YELLOW=01, RED=10
//   active_dir - direction currently owning green/yellow
//   phase      - GREEN=00, YELLOW=01, ALLRED=10
module semaforo_multi #(
    parameter int N_DIR     = 4,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    localparam int AW = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_DIR-1:0]   sensor,
    input  logic               emerg,
    output logic [2*N_DIR-1:0] light,
    output logic [AW-1:0]      active_dir,
    output logic [1:0]         phase
);

    // Timer must hold the largest dwell bound.
    localparam int MAXP0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int MAXP  = (MAXP0 > ALLRED_T) ? MAXP0 : ALLRED_T;
    localparam int TW    = $clog2(MAXP) + 1;

    localparam logic [TW-1:0] T_SAT = TW'(GREEN_MAX - 1);

    // Thresholds expressed as "cycles already spent in this state" (timer+1),
    // which keeps every comparison against a non-zero constant.
    localparam logic [TW:0] N_GMIN = (TW+1)'(GREEN_MIN);
    localparam logic [TW:0] N_GMAX = (TW+1)'(GREEN_MAX);
    localparam logic [TW:0] N_Y    = (TW+1)'(YELLOW_T);
    localparam logic [TW:0] N_AR   = (TW+1)'(ALLRED_T);

    localparam logic [1:0] LT_GREEN  = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_RED    = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   active_dir_q, active_dir_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [TW:0]     elapsed;
    logic [N_DIR-1:0] req_mask;
    logic            other_req;
    logic            own_req;
    logic            rr_found;
    logic [AW-1:0]   rr_dir;

    assign elapsed = {1'b0, timer_q} + 1'b1;

    // Requests from everyone except the current owner.
    always_comb begin
        req_mask = sensor;
        for (int d = 0; d < N_DIR; d++) begin
            if (AW'(d) == active_dir_q) begin
                req_mask[d] = 1'b0;
            end
        end
        other_req = |req_mask;
        own_req   = sensor[active_dir_q];
    end

    // Round-robin search starting just after the current owner. The index is
    // wrapped by subtraction so non-power-of-two N_DIR never yields a value
    // >= N_DIR. With no requester the owner is kept.
    always_comb begin
        int            idx;
        logic [AW-1:0] cand;
        idx      = 0;
        cand     = '0;
        rr_found = 1'b0;
        rr_dir   = active_dir_q;
        for (int k = 1; k < N_DIR; k++) begin
            idx = int'(active_dir_q) + k;
            if (idx >= N_DIR) begin
                idx = idx - N_DIR;
            end
            cand = AW'(idx);
            if (!rr_found && sensor[cand]) begin
                rr_found = 1'b1;
                rr_dir   = cand;
            end
        end
    end

    // Next-state, next-owner and dwell timer.
    always_comb begin
        state_d      = state_q;
        active_dir_d = active_dir_q;
        timer_d      = timer_q;

        case (state_q)
            ST_GREEN: begin
                // Emergency preempts green at any timer value; otherwise a
                // competitor wins once minimum green is served and either the
                // owner has gone idle or maximum green is reached.
                if (emerg) begin
                    state_d = ST_YELLOW;
                end else if ((elapsed >= N_GMIN) && other_req &&
                             (!own_req || (elapsed >= N_GMAX))) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                // Yellow always runs its full length, emergency or not.
                if (elapsed >= N_Y) begin
                    state_d = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                // An emergency parks the junction in all-red until it clears.
                if (!emerg && (elapsed >= N_AR)) begin
                    state_d      = ST_GREEN;
                    active_dir_d = rr_dir;
                end
            end
            default: begin
                state_d      = ST_GREEN;
                active_dir_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q < T_SAT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_GREEN;
            active_dir_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            active_dir_q <= active_dir_d;
            timer_q      <= timer_d;
        end
    end

    // Output decode from registers only.
    always_comb begin
        light = '0;
        for (int d = 0; d < N_DIR; d++) begin
            if (AW'(d) == active_dir_q) begin
                case (state_q)
                    ST_GREEN:  light[2*d +: 2] = LT_GREEN;
                    ST_YELLOW: light[2*d +: 2] = LT_YELLOW;
                    default:   light[2*d +: 2] = LT_RED;
                endcase
            end else begin
                light[2*d +: 2] = LT_RED;
            end
        end
    end

    assign phase      = state_q;
    assign active_dir = active_dir_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Purpose : scoreboard bench for semaforo_multi with default parameters.
// Latency : stimulus queues the expected outputs after each edge; a monitor
//           compares them on the following falling edge.
// Backpressure: none; one expectation per cycle at most.
module tb_semaforo_multi;

    localparam logic [1:0] PH_G  = 2'b00;
    localparam logic [1:0] PH_Y  = 2'b01;
    localparam logic [1:0] PH_AR = 2'b10;

    logic       clock;
    logic       reset;
    logic [3:0] sensor;
    logic       emerg;
    logic [7:0] light;
    logic [1:0] active_dir;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] dir;
        logic [7:0] lt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    semaforo_multi dut (
        .clock      (clock),
        .reset      (reset),
        .sensor     (sensor),
        .emerg      (emerg),
        .light      (light),
        .active_dir (active_dir),
        .phase      (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] mk_light(input logic [1:0] ph, input logic [1:0] dir);
        logic [7:0] l;
        l = 8'b1010_1010;
        if (ph == PH_G)      l[2*dir +: 2] = 2'b00;
        else if (ph == PH_Y) l[2*dir +: 2] = 2'b01;
        else                 l[2*dir +: 2] = 2'b10;
        return l;
    endfunction

    // Drive n cycles of constant inputs; after each edge queue the outputs
    // the design must show for the state that edge produced.
    task automatic run(input int n, input logic rst, input logic [3:0] sen,
                       input logic em, input logic [1:0] ph, input logic [1:0] dir,
                       input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            reset  = rst;
            sensor = sen;
            emerg  = em;
            @(posedge clock);
            #1;
            e.ph  = ph;
            e.dir = dir;
            e.lt  = mk_light(ph, dir);
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    // Monitor: the outputs are valid every cycle, so any pending expectation
    // is consumed on the next falling edge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (phase !== e.ph || active_dir !== e.dir || light !== e.lt) begin
                    errors++;
                    $display("FAIL %s @%0t: got phase=%b dir=%0d light=%b, want phase=%b dir=%0d light=%b",
                             t, $time, phase, active_dir, light, e.ph, e.dir, e.lt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        sensor = 4'b0000;
        emerg  = 1'b0;

        // Reset then idle: dir0 keeps green forever.
        run(2,  1'b1, 4'b0000, 1'b0, PH_G, 2'd0, "reset_state");
        run(30, 1'b0, 4'b0000, 1'b0, PH_G, 2'd0, "idle_hold");

        // Basic cycle: G 0-4, Y 5-7, AR 8, dir2 G from 9 and holds.
        run(2, 1'b1, 4'b0100, 1'b0, PH_G,  2'd0, "basic_rst");
        run(4, 1'b0, 4'b0100, 1'b0, PH_G,  2'd0, "basic_g0");
        run(3, 1'b0, 4'b0100, 1'b0, PH_Y,  2'd0, "basic_y0");
        run(1, 1'b0, 4'b0100, 1'b0, PH_AR, 2'd0, "basic_ar0");
        run(6, 1'b0, 4'b0100, 1'b0, PH_G,  2'd2, "basic_g2_hold");

        // Maximum green: owner keeps requesting, forced out after 20 cycles.
        run(2,  1'b1, 4'b0011, 1'b0, PH_G,  2'd0, "gmax_rst");
        run(19, 1'b0, 4'b0011, 1'b0, PH_G,  2'd0, "gmax_g0");
        run(3,  1'b0, 4'b0011, 1'b0, PH_Y,  2'd0, "gmax_y0");
        run(1,  1'b0, 4'b0011, 1'b0, PH_AR, 2'd0, "gmax_ar0");
        run(2,  1'b0, 4'b0011, 1'b0, PH_G,  2'd1, "gmax_g1");

        // Round-robin wrap from dir3 to dir0.
        run(2, 1'b1, 4'b1000, 1'b0, PH_G,  2'd0, "wrap_rst");
        run(4, 1'b0, 4'b1000, 1'b0, PH_G,  2'd0, "wrap_g0");
        run(3, 1'b0, 4'b1000, 1'b0, PH_Y,  2'd0, "wrap_y0");
        run(1, 1'b0, 4'b1000, 1'b0, PH_AR, 2'd0, "wrap_ar0");
        run(1, 1'b0, 4'b1000, 1'b0, PH_G,  2'd3, "wrap_g3");
        run(4, 1'b0, 4'b0101, 1'b0, PH_G,  2'd3, "wrap_g3_min");
        run(3, 1'b0, 4'b0101, 1'b0, PH_Y,  2'd3, "wrap_y3");
        run(1, 1'b0, 4'b0101, 1'b0, PH_AR, 2'd3, "wrap_ar3");
        run(2, 1'b0, 4'b0101, 1'b0, PH_G,  2'd0, "wrap_to_dir0");

        // No requester at all-red exit: dir3 keeps ownership. Emergency
        // leaves green at timer 0.
        run(2, 1'b1, 4'b1000, 1'b0, PH_G,  2'd0, "keep_rst");
        run(4, 1'b0, 4'b1000, 1'b0, PH_G,  2'd0, "keep_g0");
        run(3, 1'b0, 4'b1000, 1'b0, PH_Y,  2'd0, "keep_y0");
        run(1, 1'b0, 4'b1000, 1'b0, PH_AR, 2'd0, "keep_ar0");
        run(1, 1'b0, 4'b1000, 1'b0, PH_G,  2'd3, "keep_g3");
        run(1, 1'b0, 4'b0000, 1'b1, PH_Y,  2'd3, "keep_emerg_y3");
        run(2, 1'b0, 4'b0000, 1'b0, PH_Y,  2'd3, "keep_y3");
        run(1, 1'b0, 4'b0000, 1'b0, PH_AR, 2'd3, "keep_ar3");
        run(3, 1'b0, 4'b0000, 1'b0, PH_G,  2'd3, "keep_dir3");

        // Emergency raised at green timer 1 for 10 cycles: Y 2-4, AR 5-11,
        // then green goes to the waiting dir1.
        run(2, 1'b1, 4'b0010, 1'b0, PH_G,  2'd0, "emerg_rst");
        run(1, 1'b0, 4'b0010, 1'b0, PH_G,  2'd0, "emerg_g0");
        run(3, 1'b0, 4'b0010, 1'b1, PH_Y,  2'd0, "emerg_y0");
        run(7, 1'b0, 4'b0010, 1'b1, PH_AR, 2'd0, "emerg_ar_hold");
        run(3, 1'b0, 4'b0010, 1'b0, PH_G,  2'd1, "emerg_g1");

        // Reset mid-yellow of dir2, then a full-length green proves the
        // timer restarted; then reset mid-all-red.
        run(2, 1'b1, 4'b0100, 1'b0, PH_G,  2'd0, "midrst_rst");
        run(4, 1'b0, 4'b0100, 1'b0, PH_G,  2'd0, "midrst_g0");
        run(3, 1'b0, 4'b0100, 1'b0, PH_Y,  2'd0, "midrst_y0");
        run(1, 1'b0, 4'b0100, 1'b0, PH_AR, 2'd0, "midrst_ar0");
        run(1, 1'b0, 4'b0100, 1'b0, PH_G,  2'd2, "midrst_g2");
        run(4, 1'b0, 4'b0001, 1'b0, PH_G,  2'd2, "midrst_g2_min");
        run(2, 1'b0, 4'b0001, 1'b0, PH_Y,  2'd2, "midrst_y2");
        run(1, 1'b1, 4'b0001, 1'b0, PH_G,  2'd0, "rst_in_yellow");
        run(4, 1'b0, 4'b0100, 1'b0, PH_G,  2'd0, "post_rst_g0");
        run(3, 1'b0, 4'b0100, 1'b0, PH_Y,  2'd0, "post_rst_y0");
        run(1, 1'b0, 4'b0100, 1'b0, PH_AR, 2'd0, "post_rst_ar0");
        run(1, 1'b1, 4'b0100, 1'b0, PH_G,  2'd0, "rst_in_allred");
        run(5, 1'b0, 4'b0000, 1'b0, PH_G,  2'd0, "post_rst_idle");

        // Let the monitor drain, then confirm nothing was left unchecked.
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
